adder_arb: RTL and testbench
============================

ADDER_ARB -- requirements
Module: adder_arb

Interface
REQ-001 Parameter W, default 8: operand width of each of the four summands.
REQ-002 Parameter N, default 4: number of requesters; legal range 2..16.
REQ-003 Parameter IW, default 2: requester-id width; SHALL satisfy 2^IW >= N.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  N  per-requester request valid.
REQ-007 req_ins  input  N*(4W+1)  per-requester operand bundle; requester k occupies bits [(k+1)(4W+1)-1 : k(4W+1)].
REQ-008 Bundle packing: x [W-1:0], y [2W-1:W], z [3W-1:2W], w [4W-1:3W], cin [4W].
REQ-009 req_ready  output  N  one-hot grant/accept pulse.
REQ-010 res_valid  output  1  result valid.
REQ-011 res_ready  input  1  result consumer ready.
REQ-012 res_sum  output  W+2  x+y+z+w+cin of the accepted bundle.
REQ-013 res_zero  output  1  high when res_sum == 0.
REQ-014 res_id  output  IW  index of the requester that produced the result.
REQ-015 busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 FSM states: IDLE, CALC, HOLD.
REQ-017 IDLE, no req_valid bit set: remain in IDLE.
REQ-018 IDLE, any req_valid bit set: grant by round-robin.
  - Search starts at index last_id+1 mod N.
  - Winner g: req_ready[g]=1 for exactly that cycle (combinational from state, req_valid, last_id).
  - Capture req_ins slice g and g into internal registers; last_id <= g; next state CALC.
REQ-019 req_ready SHALL be all-zero in CALC and HOLD and at most one-hot in IDLE.
REQ-020 A request transfers only when req_valid[k] & req_ready[k]; requesters hold req_valid and req_ins until then.
REQ-021 CALC, one cycle:
  - res_sum <= sum of captured fields, computed in W+2 bits with no overflow (max 4(2^W-1)+1 < 2^(W+2)).
  - res_zero <= (sum == 0); res_id <= captured g; res_valid <= 1; next state HOLD.
REQ-022 HOLD: res_valid=1; res_sum, res_zero and res_id held stable.
  - res_ready=1: res_valid <= 0, next state IDLE.
  - res_ready=0: remain in HOLD.
REQ-023 Latency: res_valid rises 2 cycles after the accept cycle. Maximum throughput: one result per 3 cycles.
REQ-024 req_valid changes during CALC/HOLD SHALL NOT affect the captured operands or the in-flight result.
REQ-025 Pointer wrap: with last_id = N-1, the search begins at 0.
REQ-026 A requester deasserting req_valid before its grant loses no fairness position; last_id updates only on a grant.

Reset
REQ-027 While rst_n=0, regardless of clock:
  - state=IDLE, last_id=N-1 (first priority to requester 0);
  - res_valid=0, res_sum=0, res_zero=0, res_id=0;
  - captured operand registers=0; req_ready=0; busy=0.
REQ-028 Reset asserted in CALC or HOLD discards the in-flight result; no res_valid pulse follows deassertion.
REQ-029 First grant possible in the first clock edge after rst_n deasserts.

Verification (W=8, N=4)
REQ-030 Single request, requester 2 (x=1, y=2, z=3, w=4, cin=1), res_ready=1:
  - req_ready=4'b0100 for one cycle;
  - 2 cycles later res_valid=1, res_sum=11, res_zero=0, res_id=2;
  - IDLE on the next cycle.
REQ-031 Overflow bound, requester 0 (x=y=z=w=255, cin=1): res_sum=1021 (10'h3FD), res_zero=0.
REQ-032 Zero sum, all fields 0: res_sum=0, res_zero=1.
REQ-033 Fairness, all four req_valid held high from reset with res_ready=1:
  - grant order 0,1,2,3,0,1;
  - consecutive grants exactly 3 cycles apart.
REQ-034 Backpressure, res_ready=0 for 5 cycles in HOLD:
  - res_valid, res_sum and res_id stable throughout; req_ready=0 throughout;
  - release on res_ready=1 and return to IDLE.
REQ-035 Reset mid-operation, rst_n pulsed low during CALC:
  - outputs cleared immediately (asynchronously);
  - no res_valid pulse after release;
  - next grant goes to requester 0.

Source files
------------

// File: rtl/adder_arb.sv
`default_nettype none
// ============================================================================
// Module   : adder_arb
// Purpose  : Round-robin arbiter in front of a four-operand adder. One of up
//            to N requesters is granted per transaction; its operand bundle
//            {cin, w, z, y, x} is captured, summed in W+2 bits, and the
//            result is held until the consumer accepts it.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            req_valid  - [N] per-requester request valid
//            req_ins    - [N*(4W+1)] packed operand bundles, requester k at
//                         bits [(k+1)(4W+1)-1 : k(4W+1)]
//            req_ready  - [N] one-hot grant / accept pulse (IDLE only)
//            res_valid  - result valid
//            res_ready  - result consumer ready
//            res_sum    - [W+2] x+y+z+w+cin of the accepted bundle
//            res_zero   - res_sum == 0
//            res_id     - [IW] index of the requester that produced res_sum
//            busy       - state is not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module adder_arb #(
  parameter int W  = 8,
  parameter int N  = 4,   // legal range 2..16
  parameter int IW = 2    // must satisfy 2**IW >= N
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req_valid,
  input  logic [N*(4*W+1)-1:0]   req_ins,
  output logic [N-1:0]           req_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [W+1:0]           res_sum,
  output logic                   res_zero,
  output logic [IW-1:0]          res_id,
  output logic                   busy
);

  localparam int BW = 4*W + 1;   // bundle width per requester

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    last_id_q;
  logic [W-1:0]     cap_x_q, cap_y_q, cap_z_q, cap_w_q;
  logic             cap_cin_q;
  logic [IW-1:0]    cap_id_q;
  logic             res_valid_q;
  logic [W+1:0]     res_sum_q;
  logic             res_zero_q;
  logic [IW-1:0]    res_id_q;

  // --------------------------------------------------------------------------
  // Round-robin search: scan last_id+1, last_id+2, ... (mod N); first set
  // req_valid bit wins. last_id itself is checked last.
  // --------------------------------------------------------------------------
  logic             grant_found_d;
  logic [IW-1:0]    grant_id_d;
  int               scan_idx;

  always_comb begin
    grant_found_d = 1'b0;
    grant_id_d    = '0;
    scan_idx      = 0;
    for (int i = 1; i <= N; i++) begin
      scan_idx = (int'(last_id_q) + i) % N;
      if (!grant_found_d && req_valid[scan_idx]) begin
        grant_found_d = 1'b1;
        grant_id_d    = IW'(scan_idx);
      end
    end
  end

  // Grant is combinational so the requester sees its accept in the same
  // cycle; gating with rst_n keeps it quiet while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && grant_found_d) begin
      req_ready[grant_id_d] = 1'b1;
    end
  end

  logic [BW-1:0] grant_bundle_d;
  assign grant_bundle_d = req_ins[int'(grant_id_d)*BW +: BW];

  // Each operand is zero-extended to W+2 bits first, so the worst case
  // 4*(2^W-1)+1 fits without wrap.
  logic [W+1:0] sum_d;
  assign sum_d = (W+2)'(cap_x_q) + (W+2)'(cap_y_q) + (W+2)'(cap_z_q)
               + (W+2)'(cap_w_q) + (W+2)'(cap_cin_q);

  // --------------------------------------------------------------------------
  // Control FSM with registered result outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_id_q   <= IW'(N-1);      // first priority goes to requester 0
      cap_x_q     <= '0;
      cap_y_q     <= '0;
      cap_z_q     <= '0;
      cap_w_q     <= '0;
      cap_cin_q   <= 1'b0;
      cap_id_q    <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_zero_q  <= 1'b0;
      res_id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found_d) begin
            cap_x_q   <= grant_bundle_d[W-1:0];
            cap_y_q   <= grant_bundle_d[2*W-1:W];
            cap_z_q   <= grant_bundle_d[3*W-1:2*W];
            cap_w_q   <= grant_bundle_d[4*W-1:3*W];
            cap_cin_q <= grant_bundle_d[4*W];
            cap_id_q  <= grant_id_d;
            last_id_q <= grant_id_d;
            state_q   <= CALC;
          end
        end
        CALC: begin
          res_sum_q   <= sum_d;
          res_zero_q  <= (sum_d == '0);
          res_id_q    <= cap_id_q;
          res_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_zero  = res_zero_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adder_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_arb
// Purpose  : Directed self-checking bench for adder_arb (W=8, N=4, IW=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_arb;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int BW = 4*W + 1;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       req_valid;
  logic [N*BW-1:0]    req_ins;
  logic [N-1:0]       req_ready;
  logic               res_valid;
  logic               res_ready;
  logic [W+1:0]       res_sum;
  logic               res_zero;
  logic [IW-1:0]      res_id;
  logic               busy;

  int n_tests;
  int n_fail;

  adder_arb #(.W(W), .N(N), .IW(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ins   (req_ins),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_zero  (res_zero),
    .res_id    (res_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] mk(input logic [7:0] x, input logic [7:0] y,
                                       input logic [7:0] z, input logic [7:0] w,
                                       input logic c);
    return {c, w, z, y, x};
  endfunction

  task automatic set_bundle(input int id, input logic [BW-1:0] b);
    req_ins[id*BW +: BW] = b;
  endtask

  // Wait (bounded) for the DUT to be back in IDLE, sampled on negedge.
  task automatic wait_idle();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, k);
    end
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    req_ins   = '1;
    res_ready = 1'b1;
    rst_n     = 1'b0;
    #12;
    n_tests++;
    if (req_ready !== 4'b0000 || res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req_ready=%b res_valid=%b busy=%b, required 0000/0/0",
               req_ready, res_valid, busy);
    end
    n_tests++;
    if (res_sum !== 10'd0 || res_zero !== 1'b0 || res_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_res: sum=%0d zero=%b id=%0d, required 0/0/0",
               res_sum, res_zero, res_id);
    end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fairness();
    int ids[6];
    int cyc[6];
    int ng;
    int g;
    ng = 0;
    req_ins   = '0;
    req_valid = 4'hF;
    res_ready = 1'b1;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 30; c++) begin
      if (req_ready !== 4'b0000 && ng < 6) begin
        g = -1;
        case (req_ready)
          4'b0001: g = 0;
          4'b0010: g = 1;
          4'b0100: g = 2;
          4'b1000: g = 3;
          default: g = -1;
        endcase
        ids[ng] = g;
        cyc[ng] = c;
        ng++;
      end
      @(negedge clk);
      #1;
    end
    req_valid = '0;
    n_tests++;
    if (ng != 6) begin
      n_fail++;
      $display("FAIL fair_count: saw %0d grants, required 6", ng);
    end else begin
      n_tests++;
      if (ids[0] != 0 || ids[1] != 1 || ids[2] != 2 || ids[3] != 3 ||
          ids[4] != 0 || ids[5] != 1) begin
        n_fail++;
        $display("FAIL fair_order: got %0d %0d %0d %0d %0d %0d, required 0 1 2 3 0 1",
                 ids[0], ids[1], ids[2], ids[3], ids[4], ids[5]);
      end
      n_tests++;
      if (cyc[0] != 0) begin
        n_fail++;
        $display("FAIL fair_first: first grant at cycle %0d, required 0", cyc[0]);
      end
      for (int i = 1; i < 6; i++) begin
        n_tests++;
        if (cyc[i] - cyc[i-1] != 3) begin
          n_fail++;
          $display("FAIL fair_spacing[%0d]: gap %0d, required 3", i, cyc[i] - cyc[i-1]);
        end
      end
    end
    wait_idle();
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    set_bundle(2, mk(8'd1, 8'd2, 8'd3, 8'd4, 1'b1));
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    n_tests++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_grant: req_ready=%b, required 0100", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    n_tests++;
    if (req_ready !== 4'b0000 || res_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_calc: req_ready=%b res_valid=%b busy=%b, required 0000/0/1",
               req_ready, res_valid, busy);
    end
    @(negedge clk);
    n_tests++;
    if (res_valid !== 1'b1 || res_sum !== 10'd11 || res_zero !== 1'b0 || res_id !== 2'd2) begin
      n_fail++;
      $display("FAIL single_result: valid=%b sum=%0d zero=%b id=%0d, required 1/11/0/2",
               res_valid, res_sum, res_zero, res_id);
    end
    @(negedge clk);
    n_tests++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: res_valid=%b busy=%b, required 0/0", res_valid, busy);
    end
  endtask

  task automatic test_overflow();
    res_ready = 1'b1;
    set_bundle(0, mk(8'd255, 8'd255, 8'd255, 8'd255, 1'b1));
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL ovf_grant: req_ready=%b, required 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    n_tests++;
    if (res_valid !== 1'b1 || res_sum !== 10'h3FD || res_zero !== 1'b0 || res_id !== 2'd0) begin
      n_fail++;
      $display("FAIL ovf_result: valid=%b sum=%0d zero=%b id=%0d, required 1/1021/0/0",
               res_valid, res_sum, res_zero, res_id);
    end
    @(negedge clk);
    wait_idle();
  endtask

  task automatic test_zero();
    res_ready = 1'b1;
    set_bundle(3, mk(8'd0, 8'd0, 8'd0, 8'd0, 1'b0));
    @(negedge clk);
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    n_tests++;
    if (res_valid !== 1'b1 || res_sum !== 10'd0 || res_zero !== 1'b1 || res_id !== 2'd3) begin
      n_fail++;
      $display("FAIL zero_result: valid=%b sum=%0d zero=%b id=%0d, required 1/0/1/3",
               res_valid, res_sum, res_zero, res_id);
    end
    @(negedge clk);
    wait_idle();
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    res_ready = 1'b0;
    set_bundle(1, mk(8'd10, 8'd20, 8'd30, 8'd40, 1'b0));
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_grant: req_ready=%b, required 0010", req_ready);
    end
    @(negedge clk);
    // Other requesters and new operands appear mid-flight; neither may leak in.
    req_valid = 4'b1111;
    set_bundle(1, '1);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (res_valid !== 1'b1 || res_sum !== 10'd100 || res_id !== 2'd1 ||
          req_ready !== 4'b0000) begin
        n_fail++;
        bad++;
        $display("FAIL bp_hold[%0d]: valid=%b sum=%0d id=%0d req_ready=%b, required 1/100/1/0000",
                 c, res_valid, res_sum, res_id, req_ready);
      end
      @(negedge clk);
    end
    req_valid = 4'b0000;
    res_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: res_valid=%b busy=%b, required 0/0", res_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    // Part A: reset asserted between edges while a result is held.
    res_ready = 1'b0;
    set_bundle(1, mk(8'd10, 8'd20, 8'd30, 8'd40, 1'b0));
    @(negedge clk);
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    n_tests++;
    if (res_valid !== 1'b1 || res_sum !== 10'd100) begin
      n_fail++;
      $display("FAIL rst_pre: valid=%b sum=%0d, required 1/100", res_valid, res_sum);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (res_valid !== 1'b0 || res_sum !== 10'd0 || res_zero !== 1'b0 ||
        res_id !== 2'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async_hold: valid=%b sum=%0d zero=%b id=%0d busy=%b, required 0/0/0/0/0",
               res_valid, res_sum, res_zero, res_id, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Part B: reset pulsed during CALC after granting requester 1.
    res_ready = 1'b1;
    req_valid = 4'b0010;
    #1;
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL rst_b_grant: req_ready=%b, required 0010", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_async_calc: busy=%b res_valid=%b req_ready=%b, required 0/0/0000",
               busy, res_valid, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_no_pulse[%0d]: res_valid=%b busy=%b, required 0/0",
                 c, res_valid, busy);
      end
    end
    // Pointer must have returned to N-1, so requester 0 beats requester 3.
    req_valid = 4'b1001;
    #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_next_grant: req_ready=%b, required 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    wait_idle();
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_ins   = '0;
    res_ready = 1'b1;

    test_reset();
    test_fairness();
    test_single();
    test_overflow();
    test_zero();
    test_backpressure();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
